// File: rtl/snn_batch_runner.sv
// Batch sequencer for snn_core self-test: walks the stored samples, launches the core,
// waits for done with a bounded timer, and tallies pass/fail/timeout per batch.
module snn_batch_runner #(
    parameter int NUM_SAMPLES     = 10,
    parameter int SEL_WIDTH       = 4,
    parameter int DIGIT_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES  = 60000,
    parameter int TO_WIDTH        = 16,
    parameter int STOP_ON_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic                   single,
    input  logic [SEL_WIDTH-1:0]   sel_in,
    input  logic                   abort,
    output logic [SEL_WIDTH-1:0]   sample_sel,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [DIGIT_WIDTH-1:0] core_digit,
    input  logic [DIGIT_WIDTH-1:0] exp_digit,
    output logic                   result_valid,
    output logic [SEL_WIDTH-1:0]   result_sel,
    output logic [DIGIT_WIDTH-1:0] result_digit,
    output logic                   result_match,
    output logic                   result_timeout,
    output logic [SEL_WIDTH:0]     pass_count,
    output logic [SEL_WIDTH:0]     fail_count,
    output logic [SEL_WIDTH:0]     timeout_count,
    output logic                   busy,
    output logic                   batch_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    localparam logic [SEL_WIDTH:0]   NUM_SEL    = (SEL_WIDTH+1)'(NUM_SAMPLES);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL   = SEL_WIDTH'(NUM_SAMPLES - 1);
    localparam logic [TO_WIDTH-1:0]  TIMER_LOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic                 STOP_TO    = (STOP_ON_TIMEOUT != 0);

    state_t                state;
    state_t                state_nx;
    logic                  done_q;
    logic                  single_q;
    logic [TO_WIDTH-1:0]   timer;
    logic                  go_ok;
    logic                  done_edge;
    logic                  timer_zero;
    logic                  last_sample;

    // A single-mode request for a nonexistent sample is dropped rather than run.
    assign go_ok       = go & ~(single & ({1'b0, sel_in} >= NUM_SEL));
    // Only a fresh rising edge counts; a done level left over from a previous run is ignored.
    assign done_edge   = core_done & ~done_q;
    assign timer_zero  = (timer == '0);
    assign last_sample = (sample_sel == LAST_SEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        core_start   = 1'b0;
        result_valid = 1'b0;
        batch_done   = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (go_ok) begin
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge || timer_zero) begin
                    state_nx = S_REPORT;
                end
            end
            S_REPORT: begin
                result_valid = 1'b1;
                if (single_q || last_sample || (STOP_TO && result_timeout)) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_LAUNCH;
                end
            end
            S_FINISH: begin
                batch_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Abort overrides every transition, including an accepted go.
        if (abort) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q         <= 1'b0;
            single_q       <= 1'b0;
            timer          <= '0;
            sample_sel     <= '0;
            result_sel     <= '0;
            result_digit   <= '0;
            result_match   <= 1'b0;
            result_timeout <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            timeout_count  <= '0;
        end else begin
            done_q <= core_done;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (go_ok) begin
                            pass_count    <= '0;
                            fail_count    <= '0;
                            timeout_count <= '0;
                            single_q      <= single;
                            sample_sel    <= single ? sel_in : '0;
                        end
                    end
                    S_LAUNCH: begin
                        timer <= TIMER_LOAD;
                    end
                    S_WAIT: begin
                        if (done_edge) begin
                            result_sel     <= sample_sel;
                            result_digit   <= core_digit;
                            result_match   <= (core_digit == exp_digit);
                            result_timeout <= 1'b0;
                        end else if (timer_zero) begin
                            result_sel     <= sample_sel;
                            result_digit   <= '0;
                            result_match   <= 1'b0;
                            result_timeout <= 1'b1;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (result_timeout) begin
                            timeout_count <= timeout_count + 1'b1;
                        end else if (result_match) begin
                            pass_count <= pass_count + 1'b1;
                        end else begin
                            fail_count <= fail_count + 1'b1;
                        end
                        if (state_nx == S_LAUNCH) begin
                            sample_sel <= sample_sel + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_batch_runner.sv
// Bench for snn_batch_runner: two instances (continue / stop on timeout) driven by a
// behavioural core responder, scored against a per-sample reference model.
module tb_snn_batch_runner;

    localparam int NS = 10;
    localparam int SW = 4;
    localparam int DW = 4;
    localparam int TO = 100;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          single = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] sel_in = '0;

    logic [SW-1:0] sample_sel_w   [2];
    logic          core_start_w   [2];
    logic          core_done_w    [2];
    logic [DW-1:0] core_digit_w   [2];
    logic [DW-1:0] exp_digit_w    [2];
    logic          result_valid_w [2];
    logic [SW-1:0] result_sel_w   [2];
    logic [DW-1:0] result_digit_w [2];
    logic          result_match_w [2];
    logic          result_timeout_w [2];
    logic [SW:0]   pass_w [2];
    logic [SW:0]   fail_w [2];
    logic [SW:0]   to_w   [2];
    logic          busy_w [2];
    logic          batch_done_w [2];

    int            lat_tab [16];
    logic [DW-1:0] dig_tab [16];
    logic [DW-1:0] exp_tab [16];
    bit            hang_tab [16];
    bit            stale_mode = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // observed history (monitor-owned) and expectations (model-owned)
    logic [17:0]   obs_q [$];
    logic [SW-1:0] start_q [$];
    logic [17:0]   exp_q [$];
    logic [SW-1:0] exp_start_q [$];
    int            starts_n [2] = '{0, 0};
    int            done_n [2] = '{0, 0};
    int            launch_cyc = 0;
    int            base_obs, base_start, base_st1, base_dn0, base_dn1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snn_batch_runner #(.NUM_SAMPLES(NS), .SEL_WIDTH(SW), .DIGIT_WIDTH(DW),
                       .TIMEOUT_CYCLES(TO), .TO_WIDTH(TW), .STOP_ON_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .go(go), .single(single), .sel_in(sel_in), .abort(abort),
        .sample_sel(sample_sel_w[0]), .core_start(core_start_w[0]), .core_done(core_done_w[0]),
        .core_digit(core_digit_w[0]), .exp_digit(exp_digit_w[0]),
        .result_valid(result_valid_w[0]), .result_sel(result_sel_w[0]),
        .result_digit(result_digit_w[0]), .result_match(result_match_w[0]),
        .result_timeout(result_timeout_w[0]), .pass_count(pass_w[0]), .fail_count(fail_w[0]),
        .timeout_count(to_w[0]), .busy(busy_w[0]), .batch_done(batch_done_w[0]));

    snn_batch_runner #(.NUM_SAMPLES(NS), .SEL_WIDTH(SW), .DIGIT_WIDTH(DW),
                       .TIMEOUT_CYCLES(TO), .TO_WIDTH(TW), .STOP_ON_TIMEOUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .go(go), .single(single), .sel_in(sel_in), .abort(abort),
        .sample_sel(sample_sel_w[1]), .core_start(core_start_w[1]), .core_done(core_done_w[1]),
        .core_digit(core_digit_w[1]), .exp_digit(exp_digit_w[1]),
        .result_valid(result_valid_w[1]), .result_sel(result_sel_w[1]),
        .result_digit(result_digit_w[1]), .result_match(result_match_w[1]),
        .result_timeout(result_timeout_w[1]), .pass_count(pass_w[1]), .fail_count(fail_w[1]),
        .timeout_count(to_w[1]), .busy(busy_w[1]), .batch_done(batch_done_w[1]));

    // Core responder: done pulses lat_tab cycles after the launch cycle; hung samples never finish.
    for (genvar g = 0; g < 2; g++) begin : g_core
        int            due;
        bit            pending;
        logic [SW-1:0] cur;
        assign exp_digit_w[g] = exp_tab[sample_sel_w[g]];
        always @(negedge clk) begin
            if (!rst_n) begin
                pending         = 1'b0;
                due             = 0;
                cur             = '0;
                core_done_w[g]  = 1'b0;
                core_digit_w[g] = '0;
            end else begin
                core_done_w[g] = 1'b0;
                if (pending && cyc == due) begin
                    core_done_w[g]  = 1'b1;
                    core_digit_w[g] = dig_tab[cur];
                    pending         = 1'b0;
                end else if (stale_mode && !(pending && cyc == due - 1)) begin
                    core_done_w[g] = 1'b1;
                end
                if (core_start_w[g]) begin
                    cur     = sample_sel_w[g];
                    pending = !hang_tab[cur];
                    due     = cyc + lat_tab[cur];
                end
            end
        end
    end

    function automatic logic [17:0] pack(input logic [3:0] s, input logic [3:0] d,
                                         input logic m, input logic t, input int l);
        return {s, d, m, t, 8'(l)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
                if (core_start_w[g]) starts_n[g]++;
                if (batch_done_w[g]) done_n[g]++;
            end
            if (core_start_w[0]) begin
                start_q.push_back(sample_sel_w[0]);
                launch_cyc = cyc;
            end
            if (result_valid_w[0]) begin
                obs_q.push_back(pack(result_sel_w[0], result_digit_w[0], result_match_w[0],
                                     result_timeout_w[0], cyc - launch_cyc));
            end
        end
    end

    // Reference: each sample either times out after TO wait cycles or reports lat+1 after launch.
    task automatic model(input int first, input bit one, input bit stop,
                         output int np, output int nf, output int nt);
        int last;
        exp_q.delete();
        exp_start_q.delete();
        np = 0; nf = 0; nt = 0;
        last = one ? first : NS - 1;
        for (int i = first; i <= last; i++) begin
            exp_start_q.push_back(SW'(i));
            if (hang_tab[i]) begin
                nt++;
                exp_q.push_back(pack(4'(i), 4'd0, 1'b0, 1'b1, TO + 1));
                if (stop) break;
            end else if (dig_tab[i] == exp_tab[i]) begin
                np++;
                exp_q.push_back(pack(4'(i), dig_tab[i], 1'b1, 1'b0, lat_tab[i] + 1));
            end else begin
                nf++;
                exp_q.push_back(pack(4'(i), dig_tab[i], 1'b0, 1'b0, lat_tab[i] + 1));
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_run(input bit one, input int s);
        base_obs   = obs_q.size();
        base_start = start_q.size();
        base_st1   = starts_n[1];
        base_dn0   = done_n[0];
        base_dn1   = done_n[1];
        single = one;
        sel_in = SW'(s);
        go     = 1'b1;
        @(posedge clk); #1;
        go     = 1'b0;
        single = 1'b0;
    endtask

    task automatic wait_batch(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_n[0] != base_dn0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_batch_done"}, 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic score(input string tag);
        check({tag, "_nres"}, obs_q.size() - base_obs, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_obs + i < obs_q.size())
                check($sformatf("%s_res%0d", tag, i), 32'(obs_q[base_obs + i]), 32'(exp_q[i]));
        end
        check({tag, "_nstart"}, start_q.size() - base_start, exp_start_q.size());
        for (int i = 0; i < exp_start_q.size(); i++) begin
            if (base_start + i < start_q.size())
                check($sformatf("%s_start%0d", tag, i), 32'(start_q[base_start + i]),
                      32'(exp_start_q[i]));
        end
        check({tag, "_ndone"}, done_n[0] - base_dn0, 1);
    endtask

    task automatic check_counts(input string tag, input int g, input int np, input int nf,
                                input int nt);
        check({tag, "_pass"}, 32'(pass_w[g]), np);
        check({tag, "_fail"}, 32'(fail_w[g]), nf);
        check({tag, "_timeout"}, 32'(to_w[g]), nt);
    endtask

    task automatic launch_checks(input string tag, input int first);
        check({tag, "_start_latency"}, 32'(core_start_w[0]), 32'd1);
        check({tag, "_first_sel"}, 32'(sample_sel_w[0]), first);
        check_counts({tag, "_cleared"}, 0, 0, 0, 0);
    endtask

    function automatic int pick_lat();
        case ($urandom_range(0, 3))
            0:       return 1;
            1:       return TO;
            default: return $urandom_range(1, TO);
        endcase
    endfunction

    // Full batch on both instances; dut1 stops at its first timeout.
    task automatic run_batch(input string tag);
        int np, nf, nt, sp, sf, st;
        model(0, 1'b0, 1'b1, sp, sf, st);
        sp = exp_start_q.size() + 0 * sf;
        model(0, 1'b0, 1'b0, np, nf, nt);
        start_run(1'b0, 0);
        launch_checks(tag, 0);
        wait_batch(tag);
        score(tag);
        check_counts(tag, 0, np, nf, nt);
        check({tag, "_stop_starts"}, starts_n[1] - base_st1, sp);
        check({tag, "_stop_done"}, done_n[1] - base_dn1, 1);
        check({tag, "_stop_timeout"}, 32'(to_w[1]), (st > 0) ? 1 : 0);
    endtask

    task automatic wait_starts(input string tag, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (start_q.size() - base_start >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_reached"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nf, nt;
        bit saw_busy;
        for (int i = 0; i < 16; i++) begin
            lat_tab[i] = 10; dig_tab[i] = 4'(i); exp_tab[i] = 4'(i); hang_tab[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_w[0]), 0);
        check("rst_sample_sel", 32'(sample_sel_w[0]), 0);
        check("rst_core_start", 32'(core_start_w[0]), 0);
        check("rst_result_valid", 32'(result_valid_w[0]), 0);
        check("rst_batch_done", 32'(batch_done_w[0]), 0);
        check("rst_result_digit", 32'(result_digit_w[0]), 0);
        check_counts("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            lat_tab[i] = pick_lat(); dig_tab[i] = 4'(i); exp_tab[i] = 4'(i);
        end
        run_batch("all_pass");

        for (int i = 0; i < 16; i++) begin
            lat_tab[i] = pick_lat(); dig_tab[i] = 4'd3; exp_tab[i] = 4'(i);
        end
        run_batch("all_three");

        for (int i = 0; i < 16; i++) begin
            lat_tab[i] = pick_lat(); exp_tab[i] = 4'($urandom_range(0, 15));
            dig_tab[i] = exp_tab[i];
        end
        hang_tab[4] = 1'b1;
        run_batch("hang4");
        hang_tab[4] = 1'b0;

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                lat_tab[i]  = pick_lat();
                exp_tab[i]  = 4'($urandom_range(0, 15));
                dig_tab[i]  = ($urandom_range(0, 1) == 1) ? exp_tab[i] : 4'($urandom_range(0, 15));
                hang_tab[i] = ($urandom_range(0, 4) == 0);
            end
            run_batch($sformatf("rand%0d", r));
        end
        for (int i = 0; i < 16; i++) hang_tab[i] = 1'b0;

        lat_tab[7] = $urandom_range(1, TO);
        model(7, 1'b1, 1'b0, np, nf, nt);
        start_run(1'b1, 7);
        launch_checks("single7", 7);
        wait_batch("single7");
        score("single7");
        check_counts("single7", 0, np, nf, nt);

        base_start = start_q.size();
        single = 1'b1; sel_in = 4'd12; go = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy_w[0]) saw_busy = 1'b1;
        end
        go = 1'b0; single = 1'b0;
        check("single12_busy", 32'(saw_busy), 0);
        check("single12_starts", start_q.size() - base_start, 0);

        stale_mode = 1'b1;
        lat_tab[2] = TO; exp_tab[2] = 4'd9; dig_tab[2] = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        model(2, 1'b1, 1'b0, np, nf, nt);
        start_run(1'b1, 2);
        wait_batch("stale");
        score("stale");
        check_counts("stale", 0, np, nf, nt);
        stale_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            lat_tab[i] = $urandom_range(20, 60); exp_tab[i] = 4'($urandom_range(0, 15));
            dig_tab[i] = exp_tab[i];
        end
        start_run(1'b0, 0);
        wait_starts("abort", 6);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; go = 1'b0;
        check("abort_busy", 32'(busy_w[0]), 0);
        check_counts("abort_hold", 0, 5, 0, 0);
        check("abort_nres", obs_q.size() - base_obs, 5);
        abort = 1'b1; go = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_go_busy", 32'(busy_w[0]), 0);
        check("abort_no_done", done_n[0] - base_dn0, 0);
        repeat (2 * TO) @(posedge clk);
        #1;
        run_batch("after_abort");

        start_run(1'b0, 0);
        wait_starts("reset", 4);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_w[0]), 0);
        check("midrst_sel", 32'(sample_sel_w[0]), 0);
        check("midrst_result_sel", 32'(result_sel_w[0]), 0);
        check_counts("midrst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * TO) @(posedge clk);
        #1;
        check("midrst_no_done", done_n[0] - base_dn0, 0);
        run_batch("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
